// File: rtl/instruction_decode.sv
// RV32I instruction decode stage.
// Captures the fetched word from the IF/ID register, splits it into register indices, function
// fields, a sign-extended immediate and a format code, and hands the bundle to execute with a
// valid/ready handshake. A four-phase flush acknowledge releases fetch for the next instruction.
// Optional statistics counters are built when the macro DECODE_STATS_EN is defined; otherwise
// o_retired_count and o_illegal_count are tied to zero.
module instruction_decode #(
  parameter int unsigned FLUSH_MIN_CYCLES = 1  // 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_data_ready,
  input  logic [31:0] i_instruction,
  input  logic        i_ex_ready,
  output logic        o_flush,
  output logic        o_valid,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [31:0] o_imm,
  output logic [2:0]  o_format,
  output logic        o_illegal,
  output logic [15:0] o_retired_count,
  output logic [15:0] o_illegal_count
);

  // Format codes presented on o_format.
  localparam logic [2:0] FmtR   = 3'd0;
  localparam logic [2:0] FmtI   = 3'd1;
  localparam logic [2:0] FmtS   = 3'd2;
  localparam logic [2:0] FmtB   = 3'd3;
  localparam logic [2:0] FmtU   = 3'd4;
  localparam logic [2:0] FmtJ   = 3'd5;
  localparam logic [2:0] FmtIll = 3'd7;

  // Recognised RV32I major opcodes.
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_MIN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDecode, StOut, StRelease} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;

  logic [6:0]  opcode_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  funct3_q;
  logic [6:0]  funct7_q;
  logic [31:0] imm_q;
  logic [2:0]  format_q;
  logic        illegal_q;

  logic [2:0]  dec_format;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic [31:0] dec_imm;

  // State, instruction and flush counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic for the capture / decode / present / release handshake.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_data_ready) begin
          instr_d = i_instruction;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StOut;
      StOut: begin
        if (i_ex_ready) begin
          flush_cnt_d = FlushLoad;
          state_d     = StRelease;
        end
      end
      StRelease: begin
        // Waiting for ready low stops IDLE re-capturing the instruction just consumed.
        if (flush_cnt_q != 4'd0) begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end else if (!i_data_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs follow the state directly so reset clears them asynchronously.
  always_comb begin
    o_valid = (state_q == StOut);
    o_flush = (state_q == StRelease);
  end

  // Combinational decode of the latched instruction word.
  always_comb begin
    dec_format = FmtIll;
    dec_rd     = '0;
    dec_rs1    = '0;
    dec_rs2    = '0;
    dec_funct3 = '0;
    dec_funct7 = '0;
    dec_imm    = '0;

    case (instr_q[6:0])
      OpReg:                              dec_format = FmtR;
      OpImm, OpLoad, OpJalr, OpSystem:    dec_format = FmtI;
      OpStore:                            dec_format = FmtS;
      OpBranch:                           dec_format = FmtB;
      OpLui, OpAuipc:                     dec_format = FmtU;
      OpJal:                              dec_format = FmtJ;
      default:                            dec_format = FmtIll;
    endcase

    case (dec_format)
      FmtR: begin
        dec_rd     = instr_q[11:7];
        dec_rs1    = instr_q[19:15];
        dec_rs2    = instr_q[24:20];
        dec_funct3 = instr_q[14:12];
        dec_funct7 = instr_q[31:25];
      end
      FmtI: begin
        dec_rd     = instr_q[11:7];
        dec_rs1    = instr_q[19:15];
        dec_funct3 = instr_q[14:12];
        dec_imm    = {{20{instr_q[31]}}, instr_q[31:20]};
      end
      FmtS: begin
        dec_rs1    = instr_q[19:15];
        dec_rs2    = instr_q[24:20];
        dec_funct3 = instr_q[14:12];
        dec_imm    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      end
      FmtB: begin
        dec_rs1    = instr_q[19:15];
        dec_rs2    = instr_q[24:20];
        dec_funct3 = instr_q[14:12];
        dec_imm    = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                      instr_q[11:8], 1'b0};
      end
      FmtU: begin
        dec_rd  = instr_q[11:7];
        dec_imm = {instr_q[31:12], 12'b0};
      end
      FmtJ: begin
        dec_rd  = instr_q[11:7];
        dec_imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                   instr_q[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Decoded bundle registers, loaded once in DECODE and held through OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      imm_q     <= '0;
      format_q  <= '0;
      illegal_q <= 1'b0;
    end else if (state_q == StDecode) begin
      opcode_q  <= instr_q[6:0];
      rd_q      <= dec_rd;
      rs1_q     <= dec_rs1;
      rs2_q     <= dec_rs2;
      funct3_q  <= dec_funct3;
      funct7_q  <= dec_funct7;
      imm_q     <= dec_imm;
      format_q  <= dec_format;
      illegal_q <= (dec_format == FmtIll);
    end
  end

  assign o_opcode  = opcode_q;
  assign o_rd      = rd_q;
  assign o_rs1     = rs1_q;
  assign o_rs2     = rs2_q;
  assign o_funct3  = funct3_q;
  assign o_funct7  = funct7_q;
  assign o_imm     = imm_q;
  assign o_format  = format_q;
  assign o_illegal = illegal_q;

`ifdef DECODE_STATS_EN
  logic [15:0] retired_q, illegal_cnt_q;
  logic        accept;

  assign accept = (state_q == StOut) && i_ex_ready;

  // Wrapping counters of bundles taken by execute, total and illegal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q     <= '0;
      illegal_cnt_q <= '0;
    end else if (accept) begin
      retired_q <= retired_q + 16'd1;
      if (illegal_q) begin
        illegal_cnt_q <= illegal_cnt_q + 16'd1;
      end
    end
  end

  assign o_retired_count = retired_q;
  assign o_illegal_count = illegal_cnt_q;
`else
  assign o_retired_count = '0;
  assign o_illegal_count = '0;
`endif

endmodule
